// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and memory (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store controller: runs one bus access per instruction, formats load
// data and store lanes, and reports busy to the hazard unit through mem_ready.
module data_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              pipe_advance,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_err,
  data_mem_ctrl_if.master   bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, ERR} state_t;

  state_t            state, next_state;
  logic              served, start, legal, aligned, done;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_n;
  logic [DATA_W-1:0] wd_q, wd_n, rdata_q, load_fmt;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  assign start = (state == IDLE) && (mem_read || mem_write) && !served;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = mem_read;
      default:                legal = 1'b0;
    endcase
    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = !addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Store lanes are computed from the live inputs and frozen at start, so the bus is stable
  // for however long the grant takes.
  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    case (funct3[1:0])
      2'b00: begin be_n = 4'b0001 << addr[1:0];              wd_n = {4{wdata[7:0]}};  end
      2'b01: begin be_n = addr[1] ? 4'b1100 : 4'b0011;       wd_n = {2{wdata[15:0]}}; end
      default: begin be_n = 4'b1111;                         wd_n = wdata;            end
    endcase
    if (mem_read) be_n = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (legal && aligned) ? REQ : ERR;
      REQ:     if (bus.bus_gnt) next_state = we_q ? IDLE : WAIT_R;
      WAIT_R:  if (bus.bus_rvalid) next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign done = ((state == REQ) && bus.bus_gnt && we_q) ||
                ((state == WAIT_R) && bus.bus_rvalid) || (state == ERR);

  assign rbyte = bus.bus_rdata[{off_q, 3'b000} +: 8];
  assign rhalf = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_fmt = {24'b0, rbyte};
      3'b101:  load_fmt = {16'b0, rhalf};
      default: load_fmt = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      served  <= 1'b0;
    end else begin
      if (start) begin
        we_q   <= !mem_read;
        f3_q   <= funct3;
        off_q  <= addr[1:0];
        addr_q <= {addr[ADDR_W-1:2], 2'b00};
        be_q   <= be_n;
        wd_q   <= wd_n;
        // Clearing here makes rdata read 0 during the error cycle itself
        if (!(legal && aligned)) rdata_q <= '0;
      end
      if ((state == WAIT_R) && bus.bus_rvalid) rdata_q <= load_fmt;
      if (done)              served <= 1'b1;
      else if (pipe_advance) served <= 1'b0;
    end
  end

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wd_q;
  assign mem_ready     = (state == IDLE);
  assign mem_err       = (state == ERR);
  assign rdata         = rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: inputs change 1ns after posedge, outputs checked there.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, pipe_advance, mem_ready, mem_err;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  int asserts = 0;
  int fails = 0;

  data_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .pipe_advance(pipe_advance), .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_ready(mem_ready), .rdata(rdata), .mem_err(mem_err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One cycle of ID/EX enable, then the new instruction sits in EX (cycle 0 on return).
  task automatic new_instr(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    mem_read = 1'b0; mem_write = 1'b0; pipe_advance = 1'b1;
    step();
    pipe_advance = 1'b0; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    asserts++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", mem_ready); end
    asserts++; if (bus.bus_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", bus.bus_req); end
    asserts++; if (bus.bus_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", bus.bus_we); end
    asserts++; if (bus.bus_be !== 4'b0) begin fails++; $display("FAIL rst_be: got %b want 0000", bus.bus_be); end
    asserts++; if (bus.bus_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", bus.bus_addr); end
    asserts++; if (bus.bus_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h want 0", bus.bus_wdata); end
    asserts++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    asserts++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", mem_err); end
    rst = 1'b0;
  endtask

  task automatic test_lw_and_served();
    new_instr(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    asserts++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL lw_ready_c0: got %b want 1", mem_ready); end
    step();
    asserts++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL lw_ready_c1: got %b want 0", mem_ready); end
    asserts++; if (bus.bus_req !== 1'b1) begin fails++; $display("FAIL lw_req_c1: got %b want 1", bus.bus_req); end
    asserts++; if (bus.bus_addr !== 32'h100) begin fails++; $display("FAIL lw_addr: got %h want 00000100", bus.bus_addr); end
    asserts++; if (bus.bus_be !== 4'b1111) begin fails++; $display("FAIL lw_be: got %b want 1111", bus.bus_be); end
    asserts++; if (bus.bus_we !== 1'b0) begin fails++; $display("FAIL lw_we: got %b want 0", bus.bus_we); end
    bus.bus_gnt = 1'b1; step(); bus.bus_gnt = 1'b0;
    asserts++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL lw_ready_c2: got %b want 0", mem_ready); end
    asserts++; if (bus.bus_req !== 1'b0) begin fails++; $display("FAIL lw_req_c2: got %b want 0", bus.bus_req); end
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hDEADBEEF; step(); bus.bus_rvalid = 1'b0;
    asserts++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL lw_ready_c3: got %b want 1", mem_ready); end
    asserts++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got %h want deadbeef", rdata); end
    // mem_read stays high with no pipe_advance: must not re-issue
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++; if (bus.bus_req !== 1'b0 || mem_ready !== 1'b1) begin fails++; $display("FAIL served_hold: req %b ready %b want 0/1", bus.bus_req, mem_ready); end
    end
    new_instr(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    step();
    asserts++; if (bus.bus_req !== 1'b1) begin fails++; $display("FAIL served_new: got %b want 1", bus.bus_req); end
    asserts++; if (bus.bus_addr !== 32'h104) begin fails++; $display("FAIL served_new_addr: got %h want 00000104", bus.bus_addr); end
    bus.bus_gnt = 1'b1; step(); bus.bus_gnt = 1'b0;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h01020304; step(); bus.bus_rvalid = 1'b0;
    asserts++; if (rdata !== 32'h01020304) begin fails++; $display("FAIL served_new_rdata: got %h want 01020304", rdata); end
  endtask

  task automatic test_load_fmt();
    logic [2:0]  f3s [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b000, 3'b001};
    logic [31:0] as  [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] ws  [7] = '{32'h80FF1234, 32'h80FF1234, 32'h80010000, 32'h80010000,
                             32'h80FF1234, 32'h80FF1234, 32'h80FF1234};
    logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                             32'hFFFFFFFF, 32'h00000034, 32'h00001234};
    for (int i = 0; i < 7; i++) begin
      new_instr(1'b1, 1'b0, f3s[i], as[i], 32'h0);
      step();
      asserts++; if (bus.bus_addr !== {as[i][31:2], 2'b00}) begin fails++; $display("FAIL ld%0d_addr: got %h want %h", i, bus.bus_addr, {as[i][31:2], 2'b00}); end
      bus.bus_gnt = 1'b1; step(); bus.bus_gnt = 1'b0;
      bus.bus_rvalid = 1'b1; bus.bus_rdata = ws[i]; step(); bus.bus_rvalid = 1'b0;
      asserts++; if (rdata !== exp[i]) begin fails++; $display("FAIL ld%0d_rdata: got %h want %h", i, rdata, exp[i]); end
    end
  endtask

  task automatic test_sb_delayed_gnt();
    new_instr(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB);
    step();
    for (int i = 0; i < 4; i++) begin
      asserts++; if (bus.bus_req !== 1'b1 || mem_ready !== 1'b0) begin fails++; $display("FAIL sb_req_c%0d: req %b ready %b want 1/0", i, bus.bus_req, mem_ready); end
      asserts++; if (bus.bus_be !== 4'b0010 || bus.bus_we !== 1'b1) begin fails++; $display("FAIL sb_be_c%0d: be %b we %b want 0010/1", i, bus.bus_be, bus.bus_we); end
      asserts++; if (bus.bus_addr !== 32'h200 || bus.bus_wdata !== 32'hABABABAB) begin fails++; $display("FAIL sb_bus_c%0d: addr %h wdata %h want 00000200/abababab", i, bus.bus_addr, bus.bus_wdata); end
      if (i == 3) bus.bus_gnt = 1'b1;
      step();
    end
    bus.bus_gnt = 1'b0;
    asserts++; if (mem_ready !== 1'b1 || bus.bus_req !== 1'b0) begin fails++; $display("FAIL sb_done: ready %b req %b want 1/0", mem_ready, bus.bus_req); end
  endtask

  task automatic test_store_fmt();
    logic [2:0]  f3s [3] = '{3'b001, 3'b010, 3'b000};
    logic [31:0] as  [3] = '{32'h206, 32'h208, 32'h203};
    logic [31:0] wds [3] = '{32'h1234CDEF, 32'h11223344, 32'h0000005A};
    logic [3:0]  ebe [3] = '{4'b1100, 4'b1111, 4'b1000};
    logic [31:0] ewd [3] = '{32'hCDEFCDEF, 32'h11223344, 32'h5A5A5A5A};
    logic [31:0] ead [3] = '{32'h204, 32'h208, 32'h200};
    for (int i = 0; i < 3; i++) begin
      new_instr(1'b0, 1'b1, f3s[i], as[i], wds[i]);
      step();
      asserts++; if (bus.bus_be !== ebe[i] || bus.bus_wdata !== ewd[i] || bus.bus_addr !== ead[i])
        begin fails++; $display("FAIL st%0d: be %b wdata %h addr %h want %b %h %h", i, bus.bus_be, bus.bus_wdata, bus.bus_addr, ebe[i], ewd[i], ead[i]); end
      bus.bus_gnt = 1'b1; step(); bus.bus_gnt = 1'b0;
      asserts++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL st%0d_done: got %b want 1", i, mem_ready); end
    end
  endtask

  task automatic test_errors();
    logic        rds [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b010};
    logic [31:0] as  [5] = '{32'h202, 32'h100, 32'h101, 32'h100, 32'h101};
    for (int i = 0; i < 5; i++) begin
      new_instr(rds[i], !rds[i], f3s[i], as[i], 32'hFFFFFFFF);
      step();
      asserts++; if (mem_err !== 1'b1 || mem_ready !== 1'b0) begin fails++; $display("FAIL err%0d_c1: err %b ready %b want 1/0", i, mem_err, mem_ready); end
      asserts++; if (bus.bus_req !== 1'b0 || rdata !== 32'h0) begin fails++; $display("FAIL err%0d_bus: req %b rdata %h want 0/0", i, bus.bus_req, rdata); end
      step();
      asserts++; if (mem_err !== 1'b0 || mem_ready !== 1'b1 || bus.bus_req !== 1'b0) begin fails++; $display("FAIL err%0d_c2: err %b ready %b req %b want 0/1/0", i, mem_err, mem_ready, bus.bus_req); end
    end
  endtask

  task automatic test_back_to_back();
    new_instr(1'b1, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF);
    step();
    asserts++; if (bus.bus_we !== 1'b0 || bus.bus_be !== 4'b1111) begin fails++; $display("FAIL prio: we %b be %b want 0/1111", bus.bus_we, bus.bus_be); end
    bus.bus_gnt = 1'b1; step(); bus.bus_gnt = 1'b0;
    // Completion coinciding with pipe_advance leaves served set
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h0BADF00D; pipe_advance = 1'b1;
    step();
    bus.bus_rvalid = 1'b0; pipe_advance = 1'b0;
    asserts++; if (rdata !== 32'h0BADF00D) begin fails++; $display("FAIL b2b_rdata: got %h want 0badf00d", rdata); end
    for (int i = 0; i < 2; i++) begin
      step();
      asserts++; if (bus.bus_req !== 1'b0 || mem_ready !== 1'b1) begin fails++; $display("FAIL b2b_served: req %b ready %b want 0/1", bus.bus_req, mem_ready); end
    end
  endtask

  task automatic test_reset_mid();
    new_instr(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    step();
    bus.bus_gnt = 1'b1; step(); bus.bus_gnt = 1'b0;
    asserts++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL rmid_wait: got %b want 0", mem_ready); end
    rst = 1'b1; mem_read = 1'b0; step(); rst = 1'b0;
    asserts++; if (mem_ready !== 1'b1 || bus.bus_req !== 1'b0) begin fails++; $display("FAIL rmid_state: ready %b req %b want 1/0", mem_ready, bus.bus_req); end
    asserts++; if (rdata !== 32'h0) begin fails++; $display("FAIL rmid_rdata: got %h want 0", rdata); end
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h55555555; step(); bus.bus_rvalid = 1'b0;
    asserts++; if (rdata !== 32'h0 || mem_ready !== 1'b1) begin fails++; $display("FAIL rmid_late: rdata %h ready %b want 0/1", rdata, mem_ready); end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pipe_advance = 1'b0;
    funct3 = 3'b0; addr = '0; wdata = '0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    test_reset();
    test_lw_and_served();
    test_load_fmt();
    test_sb_delayed_gnt();
    test_store_fmt();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
